regfile_dump_ctrl: RTL and testbench

Debug sequencer that walks the register file's debug read port through every register and streams the contents out as bytes over a valid/ready interface to the debug UART transmitter. It sits between the debug unit's command decoder, which issues the start pulse while the CPU is halted, and the register file's debug address/data port. It gives the host a full register snapshot without touching the pipeline's A/B read ports.

---
 rtl/regfile_dump_ctrl.sv | 158 +++++++++++++++
 tb/tb_regfile_dump_ctrl.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_dump_ctrl.sv
// Walks the register file debug port and streams every register out as little-endian bytes (optional trailing XOR byte under DUMP_CHECKSUM_EN).
// Latency: start edge T -> first byte valid after edge T+2; 2 + NUM_BITS/8 cycles per register with ready held high.
// Backpressure: o_tx_valid/o_tx_data held stable until i_tx_ready; valid is a pure function of state.
module regfile_dump_ctrl #(
    parameter int NUM_BITS = 32,
    parameter int NUM_REGS = 32,
    parameter int ADDR_W   = $clog2(NUM_REGS)
) (
    input  logic                i_clk,
    input  logic                i_reset,
    input  logic                i_start,
    input  logic                i_cpu_halted,
    output logic [ADDR_W-1:0]   o_rf_addr,
    input  logic [NUM_BITS-1:0] i_rf_data,
    output logic [7:0]          o_tx_data,
    output logic                o_tx_valid,
    input  logic                i_tx_ready,
    output logic                o_busy,
    output logic                o_done
);

    localparam int BYTES  = NUM_BITS / 8;
    localparam int BYTE_W = (BYTES > 1) ? $clog2(BYTES) : 1;
    localparam logic [BYTE_W-1:0] LAST_BYTE = BYTE_W'(BYTES - 1);
    localparam logic [ADDR_W-1:0] LAST_REG  = ADDR_W'(NUM_REGS - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ADDR,
        S_LOAD,
        S_SEND,
`ifdef DUMP_CHECKSUM_EN
        S_CKSUM,
`endif
        S_DONE
    } state_t;

    state_t                state;
    state_t                state_nxt;
    logic [ADDR_W-1:0]     index;
    logic [BYTE_W-1:0]     byte_cnt;
    logic [NUM_BITS-1:0]   shift;
    logic                  last_byte;
    logic                  last_reg;
    logic                  start_ok;
`ifdef DUMP_CHECKSUM_EN
    logic [7:0]            cksum;
`endif

    assign last_byte = (byte_cnt == LAST_BYTE);
    assign last_reg  = (index == LAST_REG);
    assign start_ok  = i_start && i_cpu_halted;

    // The address comes straight from the index; it only moves on the last
    // handshake of a word, so it is stable across the ADDR+LOAD read slot.
    assign o_rf_addr = index;

    // State register; synchronous reset abandons any word in flight.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state and outputs; valid/data depend on state only, never on ready.
    always_comb begin
        state_nxt  = state;
        o_tx_valid = 1'b0;
        o_tx_data  = 8'h00;
        o_busy     = 1'b1;
        o_done     = 1'b0;
        case (state)
            S_IDLE: begin
                o_busy = 1'b0;
                if (start_ok) begin
                    state_nxt = S_ADDR;
                end
            end
            S_ADDR: state_nxt = S_LOAD;
            S_LOAD: state_nxt = S_SEND;
            S_SEND: begin
                o_tx_valid = 1'b1;
                o_tx_data  = shift[7:0];
                if (i_tx_ready && last_byte) begin
                    if (!last_reg) begin
                        state_nxt = S_ADDR;
                    end else begin
`ifdef DUMP_CHECKSUM_EN
                        state_nxt = S_CKSUM;
`else
                        state_nxt = S_DONE;
`endif
                    end
                end
            end
`ifdef DUMP_CHECKSUM_EN
            S_CKSUM: begin
                o_tx_valid = 1'b1;
                o_tx_data  = cksum;
                if (i_tx_ready) begin
                    state_nxt = S_DONE;
                end
            end
`endif
            S_DONE: begin
                o_done    = 1'b1;
                state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // Datapath: index/byte counter bookkeeping, word capture and byte shifting.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            index    <= '0;
            byte_cnt <= '0;
            shift    <= '0;
`ifdef DUMP_CHECKSUM_EN
            cksum    <= 8'h00;
`endif
        end else begin
            case (state)
                S_IDLE: begin
                    if (start_ok) begin
                        index    <= '0;
                        byte_cnt <= '0;
`ifdef DUMP_CHECKSUM_EN
                        cksum    <= 8'h00;
`endif
                    end
                end
                S_LOAD: shift <= i_rf_data;
                S_SEND: begin
                    if (i_tx_ready) begin
                        shift <= shift >> 8;
`ifdef DUMP_CHECKSUM_EN
                        cksum <= cksum ^ shift[7:0];
`endif
                        if (last_byte) begin
                            byte_cnt <= '0;
                            // Index saturates at the last register.
                            if (!last_reg) begin
                                index <= index + ADDR_W'(1);
                            end
                        end else begin
                            byte_cnt <= byte_cnt + BYTE_W'(1);
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_regfile_dump_ctrl.sv
// Directed bench for regfile_dump_ctrl: register file modelled with a negedge-registered debug read port.
module tb_regfile_dump_ctrl;

    localparam int NDATA = 128;
`ifdef DUMP_CHECKSUM_EN
    localparam int NB = NDATA + 1;
`else
    localparam int NB = NDATA;
`endif

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic        halted = 1'b0;
    logic [4:0]  rf_addr;
    logic [31:0] rf_data = 32'h0;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready = 1'b1;
    logic        busy;
    logic        done;

    int checks = 0;
    int errors = 0;

    logic [31:0] regs [32];
    logic [7:0]  q [$];
    int          cyc = 0;
    int          t_start = -1;
    int          hs_edge = -1;
    int          data_last_edge = -1;
    int          done_cnt = 0;
    int          done_edge = -1;
    int          stab_err = 0;
    logic        prev_stall = 1'b0;
    logic [7:0]  prev_data = 8'h00;
    logic        rand_ready = 1'b0;

    regfile_dump_ctrl #(.NUM_BITS(32), .NUM_REGS(32)) dut (
        .i_clk        (clk),
        .i_reset      (reset),
        .i_start      (start),
        .i_cpu_halted (halted),
        .o_rf_addr    (rf_addr),
        .i_rf_data    (rf_data),
        .o_tx_data    (tx_data),
        .o_tx_valid   (tx_valid),
        .i_tx_ready   (tx_ready),
        .o_busy       (busy),
        .o_done       (done)
    );

    always #5 clk = ~clk;

    // Register file debug port: output registered on the falling edge.
    always @(negedge clk) rf_data <= regs[rf_addr];

    // Ready driver: tied high or a random 1/0 pattern.
    initial begin
        forever begin
            @(negedge clk);
            tx_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    // Edge monitor: handshakes, start acceptance, done pulses, stall stability.
    always @(posedge clk) begin
        if (prev_stall && (!tx_valid || tx_data !== prev_data)) stab_err++;
        prev_stall = tx_valid && !tx_ready && !reset;
        prev_data  = tx_data;
        if (!reset) begin
            if (start && halted && !busy) t_start = cyc;
            if (tx_valid && tx_ready) begin
                q.push_back(tx_data);
                hs_edge = cyc;
                if (q.size() == NDATA) data_last_edge = cyc;
            end
            if (done) begin
                done_cnt++;
                done_edge = cyc;
            end
        end
        cyc = cyc + 1;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] exp_byte(input int i);
        logic [31:0] w;
        logic [7:0]  x;
        if (i < NDATA) begin
            w = regs[i / 4];
            return w[8 * (i % 4) +: 8];
        end
        x = 8'h00;
        for (int j = 0; j < NDATA; j++) begin
            w = regs[j / 4];
            x = x ^ w[8 * (j % 4) +: 8];
        end
        return x;
    endfunction

    task automatic pulse_start();
        @(negedge clk);
        halted = 1'b1;
        start  = 1'b1;
        @(negedge clk);
        start  = 1'b0;
    endtask

    task automatic wait_bytes(input string tag, input int n);
        int k = 0;
        while (q.size() < n && k < 3000) begin
            @(negedge clk);
            k++;
        end
        check(tag, 32'(q.size() >= n), 32'd1);
    endtask

    task automatic wait_done(input string tag);
        int k = 0;
        while (done_cnt == 0 && k < 3000) begin
            @(negedge clk);
            k++;
        end
        check(tag, 32'(done_cnt > 0), 32'd1);
        repeat (4) @(negedge clk);
    endtask

    task automatic check_stream(input string tag);
        int mism = 0;
        for (int i = 0; i < q.size() && i < NB; i++) begin
            if (q[i] !== exp_byte(i)) mism++;
        end
        check({tag, "_len"}, 32'(q.size()), 32'(NB));
        check({tag, "_mism"}, 32'(mism), 32'd0);
        check({tag, "_done_cnt"}, 32'(done_cnt), 32'd1);
    endtask

    task automatic clear_log();
        q.delete();
        done_cnt = 0;
        done_edge = -1;
        data_last_edge = -1;
        t_start = -1;
        stab_err = 0;
    endtask

    initial begin
        for (int k = 0; k < 32; k++) regs[k] = 32'h11110000 + 32'(k);

        // Reset state
        repeat (2) @(negedge clk);
        reset = 1'b0;
        check("rst_valid", 32'(tx_valid), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_addr", 32'(rf_addr), 32'd0);
        check("rst_data", 32'(tx_data), 32'd0);

        // Start while CPU running: must be ignored
        @(negedge clk);
        halted = 1'b0;
        start  = 1'b1;
        @(negedge clk);
        start  = 1'b0;
        repeat (4) @(negedge clk);
        check("nohalt_busy", 32'(busy), 32'd0);
        check("nohalt_valid", 32'(tx_valid), 32'd0);
        check("nohalt_bytes", 32'(q.size()), 32'd0);

        // Full dump, ready high; halted dropped mid-dump
        clear_log();
        pulse_start();
        repeat (10) @(negedge clk);
        halted = 1'b0;
        wait_done("d1_wait");
        check_stream("d1");
        check("d1_b0", 32'(q[0]), 32'h00);
        check("d1_b2", 32'(q[2]), 32'h11);
        check("d1_b4", 32'(q[4]), 32'h01);
        check("d1_b7", 32'(q[7]), 32'h11);
        check("d1_last", 32'(q[NDATA-1]), 32'h11);
        check("d1_timing", 32'(data_last_edge - t_start), 32'd192);
        check("d1_done_edge", 32'(done_edge - hs_edge), 32'd1);
`ifdef DUMP_CHECKSUM_EN
        check("d1_cksum", 32'(q[NDATA]), 32'h00);
`endif

        // Random backpressure
        clear_log();
        rand_ready = 1'b1;
        pulse_start();
        wait_done("d2_wait");
        rand_ready = 1'b0;
        check_stream("d2");
        check("d2_stable", 32'(stab_err), 32'd0);

        // Second start at byte 40 is ignored
        clear_log();
        pulse_start();
        wait_bytes("d3_wait40", 40);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done("d3_wait");
        check_stream("d3");

        // Reset at byte 50 then restart
        clear_log();
        pulse_start();
        wait_bytes("d4_wait50", 50);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("d4_valid", 32'(tx_valid), 32'd0);
        check("d4_busy", 32'(busy), 32'd0);
        check("d4_addr", 32'(rf_addr), 32'd0);
        repeat (3) @(negedge clk);
        check("d4_no_done", 32'(done_cnt), 32'd0);
        clear_log();
        pulse_start();
        wait_done("d5_wait");
        check_stream("d5");
        check("d5_b0", 32'(q[0]), 32'h00);
        check("d5_b4", 32'(q[4]), 32'h01);

`ifdef DUMP_CHECKSUM_EN
        // Checksum of A5 words with r0 cleared folds to zero
        for (int k = 0; k < 32; k++) regs[k] = 32'hA5A5A5A5;
        regs[0] = 32'h0;
        clear_log();
        pulse_start();
        wait_done("d6_wait");
        check_stream("d6");
        check("d6_b127", 32'(q[127]), 32'hA5);
        check("d6_cksum", 32'(q[128]), 32'h00);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
